cdb_arbiter: RTL
================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) among the functional-unit reservation stations.
//  - Each FU presents a completed {tag, value} with a valid/ready handshake.
//  - One winner per cycle is chosen round-robin and broadcast on a registered cdb_t.
//  - Output feeds regfile register status and all RS operand capture; sits between FUs and CDB.
// PARAMETERS
//  NUM_REQ   4   number of requesting FUs (>=2); index 0..NUM_REQ-1
//  CNT_W     16  width of the broadcast counter
// PORTS
//  clk_i          in   1                  single clock; all state on posedge
//  reset_ni       in   1                  asynchronous, active-low reset
//  flush_i        in   1                  synchronous squash: no grant this cycle; cdb_o idle next cycle
//  req_valid_i    in   NUM_REQ            FU i holds a result
//  req_tag_i      in   NUM_REQ x rs_tag_t RS tag of FU i's result
//  req_val_i      in   NUM_REQ x word32_t result value of FU i
//  req_ready_o    out  NUM_REQ            one-hot grant; FU i's result accepted this cycle
//  cdb_o          out  cdb_t              registered broadcast; .tag=NO_VAL when idle
//  bcast_cnt_o    out  CNT_W              count of broadcasts since reset (wraps)
//  err_o          out  1                  sticky: a valid request carried tag NO_VAL
// BEHAVIOUR
//  Reset (reset_ni=0, asynchronous):
//  - cdb_o.tag=NO_VAL; all other cdb_o fields 0; bcast_cnt_o=0; err_o=0; rr pointer=0.
//  - req_ready_o=0 while reset is asserted.
//  - Reset mid-broadcast drops the in-flight result; the FU must still hold valid, so it is re-arbitrated after reset.
//  Handshake:
//  - FU holds valid/tag/val stable until ready.
//  - Transfer occurs when req_valid_i[i] && req_ready_o[i].
//  - req_ready_o is combinational from valid, rr pointer and flush_i; at most one bit set.
//  Arbitration:
//  - Search from rr pointer upward, wrapping modulo NUM_REQ; first eligible requester wins.
//  - Eligible: valid && tag != NO_VAL.
//  - On a grant to i, the pointer becomes (i+1) mod NUM_REQ; with no grant the pointer holds.
//  - Starvation bound: a held request is granted within NUM_REQ cycles.
//  Latency:
//  - Grant in cycle N -> cdb_o carries {tag,val} during cycle N+1 only (exactly 1 cycle).
//  - Cycle after that: next winner, or idle.
//  - Back-to-back grants give continuous broadcasts.
//  Idle:
//  - cdb_o.tag must be NO_VAL whenever no grant occurred in the previous cycle.
//  - Mandatory: regfile status entries hold NO_VAL, and a stale tag would overwrite registers.
//  NO_VAL request:
//  - Never granted; sets err_o (sticky until reset).
//  - The FU stalls; this is illegal usage.
//  flush_i=1:
//  - req_ready_o=0 this cycle; next cycle cdb_o idle.
//  - A broadcast already registered, visible this cycle, completes unchanged.
//  - Pointer holds.
//  bcast_cnt_o:
//  - Increments by 1 in the cycle cdb_o is loaded with a grant.
//  - Wraps from 2^CNT_W-1 to 0.
//  All FUs valid every cycle: grants rotate 0,1,2,3,0,...
// CONFIGURATION
//  CDB_ARB_FIXED_PRIO_EN
//  - Defined: fixed priority, lowest index wins; rr pointer removed; no starvation bound.
//  - Undefined (default): round-robin as above.
//  - All other behaviour is identical.
// TESTING
//  - Reset: drop reset_ni mid-cycle -> cdb_o.tag=NO_VAL, bcast_cnt_o=0, err_o=0 immediately (async).
//  - Single: FU1 valid, tag ALU_2, val 32'hCAFE_CAFE -> ready_o=4'b0010 at N; cdb_o={ALU_2,CAFE_CAFE} at N+1; NO_VAL at N+2; cnt=1.
//  - Fairness: all 4 valid, held 8 cycles -> grant order 0,1,2,3,0,1,2,3; 8 broadcasts back-to-back. Fixed-prio build: grant 0 every cycle.
//  - Flush: FU2 (SHIFT_1, 32'hBEEB_BABA) valid with flush_i=1 -> no ready, cdb_o idle; flush_i=0 next cycle -> granted; broadcast one cycle later.
//  - Illegal: FU3 valid with tag NO_VAL, FU0 valid with ALU_1 -> FU0 granted; FU3 never granted; err_o=1 and sticky.
//  - Wrap: CNT_W=4, 17 broadcasts -> bcast_cnt_o=1.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// Shared types for the common data bus plus the FU-to-arbiter request interface.
// Each FU lane carries valid/tag/value toward the arbiter and receives a ready (grant) back.
package cdb_pkg;
    typedef logic [3:0]  rs_tag_t;
    typedef logic [31:0] word32_t;

    localparam rs_tag_t NO_VAL  = 4'd0;
    localparam rs_tag_t ALU_1   = 4'd1;
    localparam rs_tag_t ALU_2   = 4'd2;
    localparam rs_tag_t MUL_1   = 4'd3;
    localparam rs_tag_t SHIFT_1 = 4'd4;
    localparam rs_tag_t LSU_1   = 4'd5;

    typedef struct packed {
        rs_tag_t tag;
        word32_t val;
    } cdb_t;

    localparam cdb_t CDB_IDLE = '{tag: NO_VAL, val: 32'd0};
endpackage

interface cdb_arbiter_if #(parameter int NUM_REQ = 4);
    import cdb_pkg::*;

    logic [NUM_REQ-1:0] req_valid;
    rs_tag_t            req_tag [NUM_REQ];
    word32_t            req_val [NUM_REQ];
    logic [NUM_REQ-1:0] req_ready;

    modport master (output req_valid, output req_tag, output req_val, input req_ready);
    modport slave  (input req_valid, input req_tag, input req_val, output req_ready);
endinterface

// File: rtl/cdb_arbiter.sv
// Purpose: picks one FU result per cycle (round-robin, or fixed priority with CDB_ARB_FIXED_PRIO_EN) for the CDB.
// Latency: grant in cycle N, registered broadcast on cdb_o during cycle N+1 only; idle tag otherwise.
// Backpressure: losers and NO_VAL requests see ready low and hold; flush_i withholds all grants for the cycle.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              flush_i,
    cdb_arbiter_if.slave      req_if,
    output cdb_t              cdb_o,
    output logic [CNT_W-1:0]  bcast_cnt_o,
    output logic              err_o
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0] elig;
    logic [NUM_REQ-1:0] bad_req;
    logic               any_elig;
    logic               take;
    logic [IDX_W-1:0]   gnt_idx;

    cdb_t               cdb_q, cdb_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    always_comb begin
        elig    = '0;
        bad_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            elig[i]    = req_if.req_valid[i] && (req_if.req_tag[i] != NO_VAL);
            bad_req[i] = req_if.req_valid[i] && (req_if.req_tag[i] == NO_VAL);
        end
    end

`ifdef CDB_ARB_FIXED_PRIO_EN
    always_comb begin
        any_elig = 1'b0;
        gnt_idx  = '0;
        // Descending scan so the lowest eligible index is the last write.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (elig[i]) begin
                any_elig = 1'b1;
                gnt_idx  = IDX_W'(i);
            end
        end
    end
`else
    logic [IDX_W-1:0] ptr_q, ptr_d;

    always_comb begin : rr_search
        int idx;
        idx      = 0;
        any_elig = 1'b0;
        gnt_idx  = '0;
        // Scan farthest-from-pointer first so the closest eligible requester wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr_q) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (elig[idx]) begin
                any_elig = 1'b1;
                gnt_idx  = IDX_W'(idx);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (take) begin
            ptr_d = (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign take = any_elig && !flush_i && reset_ni;

    always_comb begin
        req_if.req_ready = '0;
        if (take) begin
            req_if.req_ready = NUM_REQ'(1) << gnt_idx;
        end
    end

    always_comb begin
        cdb_d = CDB_IDLE;
        cnt_d = cnt_q;
        err_d = err_q | (|bad_req);
        if (take) begin
            cdb_d.tag = req_if.req_tag[gnt_idx];
            cdb_d.val = req_if.req_val[gnt_idx];
            cnt_d     = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            cdb_q <= CDB_IDLE;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cdb_q <= cdb_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    assign cdb_o       = cdb_q;
    assign bcast_cnt_o = cnt_q;
    assign err_o       = err_q;
endmodule
